hazard_scoreboard: RTL

Parametrised successor to the D-stage stall unit for the pipelined MIPS core. It keeps a shift-register scoreboard of in-flight register writers for STAGES pipeline stages after D, with Tnew counting down per cycle. It adds a multiply/divide busy counter and a saturating stall-cycle performance counter. It sits beside the D/E pipeline register and drives its stall/bubble control.

---
 rtl/hazard_scoreboard_if.sv | 36 +++
 rtl/hazard_scoreboard.sv | 117 +++++++++++
 2 files changed

// File: rtl/hazard_scoreboard_if.sv
// D-stage hazard interface: D-instruction descriptor and counter clear in,
// stall/busy control and stall performance counter out.
interface hazard_scoreboard_if #(
  parameter int unsigned TW    = 3,
  parameter int unsigned CNT_W = 16
);
  logic             d_valid;
  logic [4:0]       d_rs;
  logic [TW-1:0]    d_tuse_rs;
  logic [4:0]       d_rt;
  logic [TW-1:0]    d_tuse_rt;
  logic             d_wen;
  logic [4:0]       d_dst;
  logic [TW-1:0]    d_tnew;
  logic             d_md_use;
  logic             d_md_start;
  logic             d_md_is_div;
  logic             cnt_clr;
  logic             stall;
  logic             md_busy;
  logic [CNT_W-1:0] stall_cnt;

  // Pipeline side: describes the D instruction, consumes stall control.
  modport master (
    output d_valid, d_rs, d_tuse_rs, d_rt, d_tuse_rt, d_wen, d_dst, d_tnew,
           d_md_use, d_md_start, d_md_is_div, cnt_clr,
    input  stall, md_busy, stall_cnt
  );

  // Scoreboard side.
  modport slave (
    input  d_valid, d_rs, d_tuse_rs, d_rt, d_tuse_rt, d_wen, d_dst, d_tnew,
           d_md_use, d_md_start, d_md_is_div, cnt_clr,
    output stall, md_busy, stall_cnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// D-stage stall unit: shift-register scoreboard of in-flight GPR writers with
// per-cycle Tnew countdown, mult/div busy counter and a saturating stall counter.
module hazard_scoreboard #(
  parameter int unsigned STAGES   = 3,
  parameter int unsigned TW       = 3,
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  hazard_scoreboard_if.slave  bus
);

  localparam int unsigned MW = $clog2(DIV_LAT + 1);
  localparam logic [MW-1:0] MULT_V = MW'(MULT_LAT);
  localparam logic [MW-1:0] DIV_V  = MW'(DIV_LAT);

  logic [STAGES-1:0]         vld_q,  vld_d;
  logic [STAGES-1:0][4:0]    dst_q,  dst_d;
  logic [STAGES-1:0][TW-1:0] tnew_q, tnew_d;
  logic [MW-1:0]             md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0]          stall_cnt_q, stall_cnt_d;

  logic          rs_hit, rt_hit;
  logic [TW-1:0] rs_tnew, rt_tnew;
  logic          md_busy;
  logic          stall;

  // Youngest matching writer per operand; the first hit in index order wins
  // so older slots writing the same register are shadowed.
  always_comb begin
    rs_hit  = 1'b0;
    rt_hit  = 1'b0;
    rs_tnew = '0;
    rt_tnew = '0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      if (!rs_hit && vld_q[i] && (dst_q[i] == bus.d_rs) && (bus.d_rs != 5'd0)) begin
        rs_hit  = 1'b1;
        rs_tnew = tnew_q[i];
      end
      if (!rt_hit && vld_q[i] && (dst_q[i] == bus.d_rt) && (bus.d_rt != 5'd0)) begin
        rt_hit  = 1'b1;
        rt_tnew = tnew_q[i];
      end
    end
  end

  // Zero-latency stall decision from pre-edge state and D inputs.
  always_comb begin
    md_busy = (md_cnt_q != '0);
    stall   = bus.d_valid &&
              ((rs_hit && (bus.d_tuse_rs < rs_tnew)) ||
               (rt_hit && (bus.d_tuse_rt < rt_tnew)) ||
               (bus.d_md_use && md_busy));
  end

  // Slot 0 takes the issuing instruction or a bubble; older slots shift with
  // Tnew counting down to 0. The last slot's entry falls off the end.
  always_comb begin
    vld_d  = '0;
    dst_d  = '0;
    tnew_d = '0;
    if (bus.d_valid && !stall) begin
      vld_d[0]  = bus.d_wen;
      dst_d[0]  = bus.d_dst;
      tnew_d[0] = bus.d_tnew;
    end
    for (int unsigned i = 1; i < STAGES; i++) begin
      vld_d[i]  = vld_q[i-1];
      dst_d[i]  = dst_q[i-1];
      tnew_d[i] = (tnew_q[i-1] == '0) ? '0 : tnew_q[i-1] - TW'(1);
    end
  end

  // Mult/div busy countdown, reloaded when a start instruction leaves D.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (bus.d_valid && bus.d_md_start && !stall) begin
      md_cnt_d = bus.d_md_is_div ? DIV_V : MULT_V;
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - MW'(1);
    end
  end

  // Stall performance counter: clear wins over a saturating increment.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (bus.cnt_clr) begin
      stall_cnt_d = '0;
    end else if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q       <= '0;
      dst_q       <= '0;
      tnew_q      <= '0;
      md_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      vld_q       <= vld_d;
      dst_q       <= dst_d;
      tnew_q      <= tnew_d;
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.stall     = stall;
  assign bus.md_busy   = md_busy;
  assign bus.stall_cnt = stall_cnt_q;

endmodule
